// File: rtl/int_prio_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : int_prio_ctrl
// Description : Fixed-priority nested interrupt controller with edge/level
//               capture, maskable lines, non-maskable overflow on line 0.
// Revision    : 1.0 - initial release
// ============================================================================
module int_prio_ctrl #(
    parameter int N_IRQ     = 8,
    parameter int EDGE_MODE = 1,
    parameter int ID_W      = $clog2(N_IRQ)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_IRQ-1:0] irq,
    input  logic             ovf,
    input  logic             mask_we,
    input  logic [N_IRQ-1:0] mask_din,
    input  logic             ack,
    input  logic             reti,
    output logic             req,
    output logic [N_IRQ-1:0] vec,
    output logic [ID_W-1:0]  vec_id,
    output logic [N_IRQ-1:0] in_service,
    output logic             err
);

    logic [N_IRQ-1:0] r_pending;
    logic [N_IRQ-1:0] r_mask;
    logic [N_IRQ-1:0] r_in_service;
    logic [N_IRQ-1:0] r_irq_hist;
    logic             r_hist_valid;
    logic             r_ovf_pend;
    logic             r_err;
    logic             r_req;
    logic [N_IRQ-1:0] r_vec;
    logic [ID_W-1:0]  r_vec_id;

    logic             w_ack_ok;
    logic             w_reti_ok;
    logic [N_IRQ-1:0] w_cap;
    logic [N_IRQ-1:0] w_pend_nxt;
    logic             w_ovf_pend_nxt;
    logic [N_IRQ-1:0] w_isr_after_reti;
    logic [N_IRQ-1:0] w_isr_nxt;
    logic [N_IRQ-1:0] w_elig;
    logic [N_IRQ-1:0] w_sel_oh;
    logic [N_IRQ-1:0] w_isr_low;
    logic [ID_W-1:0]  w_sel_id;
    logic             w_req;
    logic             w_present;

    always_comb begin
        w_ack_ok  = ack & r_req;
        w_reti_ok = reti & (|r_in_service);

        // History is not trusted until it has been loaded once after reset,
        // so a line held high through reset release is not seen as an edge.
        if (EDGE_MODE != 0)
            w_cap = irq & ~r_irq_hist & {N_IRQ{r_hist_valid}};
        else
            w_cap = irq;

        // Capture is ORed after the ack clear so a same-cycle set wins.
        w_pend_nxt     = (r_pending & ~(w_ack_ok ? r_vec : '0)) | w_cap
                         | {{(N_IRQ-1){1'b0}}, ovf};
        w_ovf_pend_nxt = ovf | (r_ovf_pend & ~(w_ack_ok & r_vec[0]));

        w_isr_after_reti = w_reti_ok ? (r_in_service & (r_in_service - 1'b1))
                                     : r_in_service;
        w_isr_nxt        = w_isr_after_reti | (w_ack_ok ? r_vec : '0);

        w_elig    = r_pending & (r_mask | {{(N_IRQ-1){1'b0}}, r_ovf_pend});
        w_sel_oh  = w_elig & (~w_elig + 1'b1);
        w_isr_low = r_in_service & (~r_in_service + 1'b1);

        w_sel_id = '0;
        for (int i = 0; i < N_IRQ; i++) begin
            if (w_sel_oh[i]) w_sel_id = ID_W'(i);
        end

        // Both operands are one-hot, so numeric compare equals index compare.
        w_req     = (|w_elig) && ((r_in_service == '0) || (w_sel_oh < w_isr_low));
        w_present = w_req & ~w_ack_ok;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pending    <= '0;
            r_mask       <= '1;
            r_in_service <= '0;
            r_irq_hist   <= '0;
            r_hist_valid <= 1'b0;
            r_ovf_pend   <= 1'b0;
            r_err        <= 1'b0;
            r_req        <= 1'b0;
            r_vec        <= '0;
            r_vec_id     <= '0;
        end else begin
            r_pending    <= w_pend_nxt;
            r_ovf_pend   <= w_ovf_pend_nxt;
            r_in_service <= w_isr_nxt;
            r_irq_hist   <= irq;
            r_hist_valid <= 1'b1;
            r_err        <= r_err | (ack & ~r_req) | (reti & ~(|r_in_service));
            if (mask_we) r_mask <= mask_din;
            r_req        <= w_present;
            r_vec        <= w_present ? w_sel_oh : '0;
            r_vec_id     <= w_present ? w_sel_id : '0;
        end
    end

    assign req        = r_req;
    assign vec        = r_vec;
    assign vec_id     = r_vec_id;
    assign in_service = r_in_service;
    assign err        = r_err;

endmodule
`default_nettype wire

// File: tb/tb_int_prio_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_int_prio_ctrl
// Description : Scoreboard bench for int_prio_ctrl, edge and level variants.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_int_prio_ctrl;

    localparam int c_N = 8;

    typedef struct {
        int          dut;
        string       name;
        bit          req;
        int          vid;
        logic [7:0]  isr;
        bit          err;
    } exp_t;

    exp_t q[$];

    logic       clk = 1'b0;
    logic       r_rst = 1'b1;
    logic [7:0] r_irq0 = '0, r_irq1 = '0;
    logic       r_ovf0 = 1'b0;
    logic       r_mwe0 = 1'b0;
    logic [7:0] r_mdin0 = 8'hFF;
    logic       r_ack0 = 1'b0, r_ack1 = 1'b0;
    logic       r_reti0 = 1'b0, r_reti1 = 1'b0;
    logic       r_chk = 1'b0;

    logic       w_req0, w_req1, w_err0, w_err1;
    logic [7:0] w_vec0, w_vec1, w_isr0, w_isr1;
    logic [2:0] w_id0, w_id1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    int_prio_ctrl #(.N_IRQ(c_N), .EDGE_MODE(1)) u_edge (
        .clk(clk), .reset(r_rst), .irq(r_irq0), .ovf(r_ovf0),
        .mask_we(r_mwe0), .mask_din(r_mdin0), .ack(r_ack0), .reti(r_reti0),
        .req(w_req0), .vec(w_vec0), .vec_id(w_id0), .in_service(w_isr0), .err(w_err0)
    );

    int_prio_ctrl #(.N_IRQ(c_N), .EDGE_MODE(0)) u_level (
        .clk(clk), .reset(r_rst), .irq(r_irq1), .ovf(1'b0),
        .mask_we(1'b0), .mask_din(8'hFF), .ack(r_ack1), .reti(r_reti1),
        .req(w_req1), .vec(w_vec1), .vec_id(w_id1), .in_service(w_isr1), .err(w_err1)
    );

    // Monitor: pops one expectation per sample strobe and compares.
    always @(negedge clk) begin
        if (r_chk) begin
            exp_t       e;
            logic       a_req, a_err;
            logic [7:0] a_vec, a_isr, e_vec;
            logic [2:0] a_id;
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL scoreboard_empty: no expectation queued");
            end else begin
                e = q.pop_front();
                if (e.dut == 0) begin
                    a_req = w_req0; a_vec = w_vec0; a_id = w_id0; a_isr = w_isr0; a_err = w_err0;
                end else begin
                    a_req = w_req1; a_vec = w_vec1; a_id = w_id1; a_isr = w_isr1; a_err = w_err1;
                end
                e_vec = e.req ? (8'h01 << e.vid) : 8'h00;
                if (a_req !== e.req || a_vec !== e_vec || a_id !== 3'(e.req ? e.vid : 0) ||
                    a_isr !== e.isr || a_err !== e.err) begin
                    bad++;
                    $display("FAIL %s: got req=%0b vec=%02h id=%0d isr=%02h err=%0b, want req=%0b vec=%02h id=%0d isr=%02h err=%0b",
                             e.name, a_req, a_vec, a_id, a_isr, a_err,
                             e.req, e_vec, e.req ? e.vid : 0, e.isr, e.err);
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_st(input int d, input string nm, input bit rq, input int vid,
                             input logic [7:0] isr, input bit er);
        exp_t e;
        e.dut = d; e.name = nm; e.req = rq; e.vid = vid; e.isr = isr; e.err = er;
        q.push_back(e);
        r_chk = 1'b1;
        @(negedge clk);
        #1;
        r_chk = 1'b0;
    endtask

    task automatic pulse0(input int line);
        r_irq0[line] = 1'b1; step(1);
        r_irq0[line] = 1'b0; step(1);
    endtask

    task automatic ack0();
        r_ack0 = 1'b1; step(1); r_ack0 = 1'b0;
    endtask

    task automatic reti0();
        r_reti0 = 1'b1; step(1); r_reti0 = 1'b0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        step(2);
        r_rst = 1'b0;
        expect_st(0, "reset_edge", 0, 0, 8'h00, 0);
        expect_st(1, "reset_level", 0, 0, 8'h00, 0);
        step(1);

        // Single interrupt, two-cycle latency, then ack.
        pulse0(5);
        expect_st(0, "irq5_req", 1, 5, 8'h00, 0);
        ack0();
        expect_st(0, "irq5_ack", 0, 0, 8'h20, 0);

        // Nested preemption by a higher-priority line.
        pulse0(2);
        expect_st(0, "irq2_preempt", 1, 2, 8'h20, 0);
        ack0();
        expect_st(0, "irq2_ack", 0, 0, 8'h24, 0);
        reti0();
        expect_st(0, "reti_inner", 0, 0, 8'h20, 0);
        reti0();
        expect_st(0, "reti_outer", 0, 0, 8'h00, 0);

        // Lower priority blocked while a higher line is serviced.
        pulse0(2);
        ack0();
        pulse0(6);
        step(1);
        expect_st(0, "irq6_blocked", 0, 0, 8'h04, 0);
        reti0();
        step(1);
        expect_st(0, "irq6_after_reti", 1, 6, 8'h00, 0);
        ack0();
        reti0();
        expect_st(0, "irq6_done", 0, 0, 8'h00, 0);

        // Overflow is non-maskable; masked irq[0] is held pending.
        r_mwe0 = 1'b1; r_mdin0 = 8'hFE; step(1); r_mwe0 = 1'b0;
        r_ovf0 = 1'b1; step(1); r_ovf0 = 1'b0; step(1);
        expect_st(0, "ovf_nmi", 1, 0, 8'h00, 0);
        ack0();
        reti0();
        pulse0(0);
        step(1);
        expect_st(0, "irq0_masked", 0, 0, 8'h00, 0);
        r_mwe0 = 1'b1; r_mdin0 = 8'hFF; step(1); r_mwe0 = 1'b0; step(1);
        expect_st(0, "irq0_unmasked", 1, 0, 8'h00, 0);
        ack0();
        reti0();
        expect_st(0, "irq0_done", 0, 0, 8'h00, 0);

        // Simultaneous reti and ack: reti applied first.
        pulse0(5);
        ack0();
        pulse0(2);
        r_ack0 = 1'b1; r_reti0 = 1'b1; step(1); r_ack0 = 1'b0; r_reti0 = 1'b0;
        expect_st(0, "ack_reti_same", 0, 0, 8'h04, 0);
        reti0();

        // Protocol errors are sticky.
        ack0();
        expect_st(0, "err_ack_noreq", 0, 0, 8'h00, 1);
        reti0();
        step(2);
        expect_st(0, "err_sticky", 0, 0, 8'h00, 1);

        // Reset mid-service, with irq[7] held through release.
        pulse0(3);
        ack0();
        r_irq0[7] = 1'b1;
        r_rst = 1'b1; step(2); r_rst = 1'b0; step(3);
        expect_st(0, "reset_mid_service", 0, 0, 8'h00, 0);
        r_irq0[7] = 1'b0;
        reti0();
        expect_st(0, "reti_after_reset", 0, 0, 8'h00, 1);

        // Level mode: held line re-pends on ack, re-presented after reti.
        r_irq1[3] = 1'b1; step(2);
        expect_st(1, "lvl_req", 1, 3, 8'h00, 0);
        r_ack1 = 1'b1; step(1); r_ack1 = 1'b0;
        expect_st(1, "lvl_ack", 0, 0, 8'h08, 0);
        step(3);
        expect_st(1, "lvl_hold", 0, 0, 8'h08, 0);
        r_reti1 = 1'b1; step(1); r_reti1 = 1'b0; step(1);
        expect_st(1, "lvl_after_reti", 1, 3, 8'h00, 0);
        r_irq1[3] = 1'b0;
        r_ack1 = 1'b1; step(1); r_ack1 = 1'b0;
        r_reti1 = 1'b1; step(1); r_reti1 = 1'b0; step(1);
        expect_st(1, "lvl_done", 0, 0, 8'h00, 0);

        step(2);
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: %0d left, want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/int_prio_ctrl.md
INT_PRIO_CTRL -- requirements
Module: int_prio_ctrl

Interface
REQ-001 SHALL have parameter N_IRQ, default 8, meaning the number of interrupt lines (2..32); line 0 is highest priority.
REQ-002 SHALL have parameter EDGE_MODE, default 1, meaning 1 = rising-edge capture and 0 = level capture.
REQ-003 SHALL have parameter ID_W, default $clog2(N_IRQ), meaning the width of the binary vector id.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 irq  input  N_IRQ  external interrupt lines.
REQ-007 ovf  input  1  ALU overflow exception; non-maskable; captured as a request on line 0.
REQ-008 mask_we  input  1  write strobe for the mask register.
REQ-009 mask_din  input  N_IRQ  new mask value; bit set = line enabled.
REQ-010 ack  input  1  CPU has taken the presented interrupt (call vector issued this cycle).
REQ-011 reti  input  1  CPU executes return-from-interrupt.
REQ-012 req  output  1  interrupt request to the control unit.
REQ-013 vec  output  N_IRQ  one-hot selected line; all zero when req=0.
REQ-014 vec_id  output  ID_W  binary index of vec; 0 when req=0.
REQ-015 in_service  output  N_IRQ  lines currently being serviced, nested.
REQ-016 err  output  1  sticky protocol-error flag.

Function
REQ-017 Capture: EDGE_MODE=1 SHALL set pending[i] when irq[i] is 1 this cycle and was 0 in the previous cycle; EDGE_MODE=0 SHALL set pending[i] whenever irq[i]=1.
REQ-018 ovf=1 SHALL set pending[0] regardless of EDGE_MODE and mask.
REQ-019 Eligible lines SHALL be pending & (mask | 1<<0 when the pending[0] source is ovf); line 0 SHALL also obey the mask for irq[0]-only sources.
REQ-020 Selection: the lowest-index eligible line SHALL be chosen (fixed priority).
REQ-021 Preemption: req SHALL be 1 only if the selected index is strictly lower than the lowest set bit of in_service, or in_service==0.
REQ-022 req, vec, and vec_id SHALL be registered outputs, valid one cycle after the pending/mask/in_service state that produced them.
REQ-023 ack with req=1 SHALL, at the edge, clear pending[vec_id], set in_service[vec_id], and drop req the next cycle.
REQ-024 ack with req=0 SHALL be ignored and SHALL set err.
REQ-025 reti SHALL clear the lowest set bit of in_service, which is the most recent nesting level.
REQ-026 reti with in_service==0 SHALL be ignored and SHALL set err.
REQ-027 Simultaneous ack and reti SHALL apply reti first, then ack, in the same edge.
REQ-028 A new capture on the same line as an ack clear in the same cycle: set SHALL win, and pending stays 1.
REQ-029 A line already in service that is re-captured SHALL stay pending and SHALL be presented only after its own reti.
REQ-030 mask_we SHALL update the mask at the edge; masking a pending line SHALL hold it pending without clearing it.
REQ-031 Maximum nesting depth SHALL be N_IRQ, which is inherent since in_service is one bit per line.

Reset
REQ-032 reset=1 at the edge SHALL clear pending, in_service, err, req, vec, vec_id, and the edge-history register.
REQ-033 Reset SHALL set the mask to all ones.
REQ-034 Reset SHALL take priority over ack, reti, mask_we, and capture in the same cycle.
REQ-035 After reset mid-service, the CPU SHALL see in_service==0; a subsequent reti SHALL flag err.
REQ-036 EDGE_MODE=1: an irq held high through reset release SHALL NOT be captured as an edge, because history resets to 0 and is reloaded in the first cycle.

Verification
REQ-037 N_IRQ=8, EDGE_MODE=1: pulse irq[5] -> req=1, vec=8'h20, vec_id=5 two cycles later; ack -> in_service=8'h20, req=0.
REQ-038 in_service=8'h20, pulse irq[2] -> req=1, vec_id=2; ack -> in_service=8'h24; reti -> in_service=8'h20; reti -> 8'h00.
REQ-039 in_service=8'h04, pulse irq[6] -> req stays 0; after reti -> req=1, vec_id=6.
REQ-040 mask=8'hFE, ovf=1 -> req=1, vec_id=0 (non-maskable); irq[0] pulse with mask bit 0 clear and no ovf -> no req.
REQ-041 ack with req=0 -> err=1 and no state change; reti with in_service=0 -> err stays 1 until reset.
REQ-042 EDGE_MODE=0, irq[3] held high: ack -> pending[3] re-set, in_service=8'h08, req=0 until reti, then req=1, vec_id=3.
